// File: rtl/store_queue_param.sv
// In-order store queue: allocate, commit by ROB tag, drain to the data cache, flush, and load lookup.
// Define SB_BYPASS_EN to enable store-to-load forwarding; otherwise overlapping loads stall.
module store_queue_param #(
    parameter int WORD_SIZE       = 32,
    parameter int ROB_ENTRY_WIDTH = 6,
    parameter int DEPTH           = 4,
    parameter int SIZE_WIDTH      = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_valid,
    input  logic [WORD_SIZE-1:0]         alloc_addr,
    input  logic [WORD_SIZE-1:0]         alloc_data,
    input  logic [SIZE_WIDTH-1:0]        alloc_size,
    input  logic [ROB_ENTRY_WIDTH-1:0]   alloc_rob_id,
    input  logic                         alloc_exception,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic                         commit_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0]   commit_rob_id,
    output logic                         drain_valid,
    output logic [WORD_SIZE-1:0]         drain_addr,
    output logic [WORD_SIZE-1:0]         drain_data,
    output logic [SIZE_WIDTH-1:0]        drain_size,
    input  logic                         drain_ack,
    input  logic                         flush,
    input  logic                         load_valid,
    input  logic [WORD_SIZE-1:0]         load_addr,
    input  logic [SIZE_WIDTH-1:0]        load_size,
    output logic                         bypass_hit,
    output logic [WORD_SIZE-1:0]         bypass_data,
    output logic                         bypass_stall
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_PEND = 2'd1,
        ST_COMM = 2'd2
    } entry_state_e;

    // Byte lanes touched by an access of the given size at the given word offset.
    function automatic logic [3:0] byte_mask(input logic [1:0] off, input logic [SIZE_WIDTH-1:0] sz);
        logic [3:0] m;
        case (sz)
            SIZE_WIDTH'(0): m = 4'b0001 << off;
            SIZE_WIDTH'(1): m = 4'b0011 << off;
            SIZE_WIDTH'(2): m = 4'b1111;
            default:        m = 4'b1111;
        endcase
        return m;
    endfunction

    entry_state_e                state_q [DEPTH];
    entry_state_e                state_d [DEPTH];
    logic [WORD_SIZE-1:0]        addr_q  [DEPTH];
    logic [WORD_SIZE-1:0]        data_q  [DEPTH];
    logic [SIZE_WIDTH-1:0]       size_q  [DEPTH];
    logic [ROB_ENTRY_WIDTH-1:0]  rob_q   [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] n_comm_s;
    logic             pop_s;
    logic             alloc_s;

    assign full        = (count_q == DEPTH_CNT);
    assign count       = count_q;
    assign drain_valid = (state_q[head_q] == ST_COMM);
    assign drain_addr  = addr_q[head_q];
    assign drain_data  = data_q[head_q];
    assign drain_size  = size_q[head_q];

    // Next entry states: commit first, then pop, then flush, then the new allocation.
    always_comb begin
        pop_s    = drain_ack && (state_q[head_q] == ST_COMM);
        alloc_s  = alloc_valid && !alloc_exception && !flush && (!full || pop_s);
        n_comm_s = '0;
        count_d  = '0;
        state_d  = state_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (commit_valid && (state_q[i] == ST_PEND) && (rob_q[i] == commit_rob_id)) begin
                state_d[i] = ST_COMM;
            end else begin
                state_d[i] = state_q[i];
            end
            if (state_d[i] == ST_COMM) begin
                n_comm_s = n_comm_s + CNT_W'(1);
            end else begin
                n_comm_s = n_comm_s;
            end
        end
        if (pop_s) begin
            state_d[head_q] = ST_FREE;
        end else begin
            state_d[head_q] = state_d[head_q];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (flush && (state_d[i] == ST_PEND)) begin
                state_d[i] = ST_FREE;
            end else begin
                state_d[i] = state_d[i];
            end
        end
        if (alloc_s) begin
            state_d[tail_q] = ST_PEND;
        end else begin
            state_d[tail_q] = state_d[tail_q];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (state_d[i] != ST_FREE) begin
                count_d = count_d + CNT_W'(1);
            end else begin
                count_d = count_d;
            end
        end
        head_d = pop_s ? (head_q + PTR_W'(1)) : head_q;
        // Surviving committed entries sit contiguously from the old head.
        if (flush) begin
            tail_d = head_q + PTR_W'(n_comm_s);
        end else if (alloc_s) begin
            tail_d = tail_q + PTR_W'(1);
        end else begin
            tail_d = tail_q;
        end
    end

    // Pointer, occupancy and entry storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= ST_FREE;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                size_q[i]  <= '0;
                rob_q[i]   <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            state_q <= state_d;
            if (alloc_s) begin
                addr_q[tail_q] <= alloc_addr;
                data_q[tail_q] <= alloc_data;
                size_q[tail_q] <= alloc_size;
                rob_q[tail_q]  <= alloc_rob_id;
            end
        end
    end

    logic [3:0]       lmask_s;
    logic             found_s;
    logic             match_s;
    logic [PTR_W-1:0] idx_s;
`ifdef SB_BYPASS_EN
    logic [PTR_W-1:0]     sel_s;
    logic [3:0]           smask_s;
    logic                 cover_s;
    logic [WORD_SIZE-1:0] lane_s;
    logic [WORD_SIZE-1:0] shift_s;
    logic [WORD_SIZE-1:0] keep_s;
`endif

    // Age-ordered scan from head; the last overlapping entry seen is the youngest.
    always_comb begin
        lmask_s = byte_mask(load_addr[1:0], load_size);
        found_s = 1'b0;
        match_s = 1'b0;
        idx_s   = '0;
`ifdef SB_BYPASS_EN
        sel_s   = '0;
        smask_s = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx_s   = head_q + PTR_W'(k);
            match_s = (state_q[idx_s] != ST_FREE)
                   && (addr_q[idx_s][WORD_SIZE-1:2] == load_addr[WORD_SIZE-1:2])
                   && ((byte_mask(addr_q[idx_s][1:0], size_q[idx_s]) & lmask_s) != 4'b0000);
            found_s = found_s | match_s;
`ifdef SB_BYPASS_EN
            sel_s   = match_s ? idx_s : sel_s;
            smask_s = match_s ? byte_mask(addr_q[idx_s][1:0], size_q[idx_s]) : smask_s;
`endif
        end
    end

`ifdef SB_BYPASS_EN
    // Forwarding: place store bytes on their lanes, then right-align the load's lanes.
    always_comb begin
        cover_s      = ((smask_s & lmask_s) == lmask_s);
        bypass_hit   = load_valid && found_s && cover_s;
        bypass_stall = load_valid && found_s && !cover_s;
        if (size_q[sel_s] == SIZE_WIDTH'(2)) begin
            lane_s = data_q[sel_s];
        end else begin
            lane_s = data_q[sel_s] << {addr_q[sel_s][1:0], 3'b000};
        end
        shift_s = lane_s >> {load_addr[1:0], 3'b000};
        case (load_size)
            SIZE_WIDTH'(0): keep_s = WORD_SIZE'(32'h0000_00FF);
            SIZE_WIDTH'(1): keep_s = WORD_SIZE'(32'h0000_FFFF);
            default:        keep_s = {WORD_SIZE{1'b1}};
        endcase
        bypass_data = bypass_hit ? (shift_s & keep_s) : '0;
    end
`else
    assign bypass_hit   = 1'b0;
    assign bypass_data  = '0;
    assign bypass_stall = load_valid && found_s;
`endif

endmodule
